signed_mul_sequencer: RTL and testbench
=======================================

// Module: signed_mul_sequencer
// PURPOSE
//  Front/back end for the bit-pair unsigned multiplier (module Multiplier, WIDTH-bit operands, 2*WIDTH product).
//  - Front end: accepts a signed or unsigned multiply request on a valid/ready handshake, converts the operands
//    to magnitudes and drives the multiplier's start/done interface.
//  - Back end: captures the 2*WIDTH product, re-applies the sign and returns product plus condition flags.
//  Sits between the execute-unit operand path and the Multiplier.
// PARAMETERS
//  WIDTH  32  operand width; even, >=4; 2*WIDTH product. Bit 0 = MSB on all buses.
// PORTS
//  clock          in   1        clock, rising edge
//  reset          in   1        asynchronous, active-high
//  req_valid      in   1        request present
//  req_ready      out  1        sequencer can accept a request
//  req_signed     in   1        1 = two's-complement operands, 0 = unsigned
//  req_a          in   WIDTH    multiplier operand
//  req_b          in   WIDTH    multiplicand operand
//  mul_start      out  1        start to the Multiplier
//  mul_multiplier out  WIDTH    |a| to the Multiplier
//  mul_multiplicand out WIDTH   |b| to the Multiplier
//  mul_result     in   2*WIDTH  unsigned product from the Multiplier
//  mul_done       in   1        Multiplier done (1 when idle, 0 while busy)
//  rsp_valid      out  1        response present
//  rsp_ready      in   1        consumer accepts response
//  rsp_product    out  2*WIDTH  final product
//  rsp_flags      out  3        {ovf, neg, zero}
// BEHAVIOUR
//  Reset values: req_ready=0, mul_start=0, mul_multiplier=0, mul_multiplicand=0, rsp_valid=0, rsp_product=0,
//    rsp_flags=0. State = IDLE. Reset at any time, including mid-multiply, aborts the operation and drops
//    any pending response. The Multiplier shares the same reset.
//  FSM states:
//  - IDLE: req_ready=1.
//    - On req_valid&req_ready: latch sign = req_signed & (a[0]^b[0]).
//    - Register magnitudes: signed -> two's-negate negative operands, so 0x80..0 stays 0x80..0 (magnitude
//      2^(W-1)); unsigned -> pass through.
//    - Go to ISSUE.
//  - ISSUE: mul_start=1 and operand outputs held stable. Stay until mul_done==0 is sampled, then go to WAIT.
//    mul_start drops on that transition.
//  - WAIT: mul_start=0. On mul_done==1, register mul_result and go to FIX. A done seen while in ISSUE is never
//    treated as completion; this guards against the idle-high done.
//  - FIX (1 cycle):
//    - product = sign ? two's-negate(result) : result, modulo 2^(2W).
//    - zero = (product==0).
//    - neg = req_signed & product[0].
//    - ovf: signed -> product[0:W] not all equal; unsigned -> product[0:W-1] != 0.
//    - Load rsp_* and go to RESP.
//  - RESP: rsp_valid=1; rsp_product/rsp_flags stable while rsp_valid&!rsp_ready. On rsp_ready go to IDLE.
//    req_ready=0 throughout; no request overlap and no bypass.
//  Latency at W=32, rsp_ready=1: ISSUE 1 cycle, Multiplier busy W/2+1 cycles, FIX 1, RESP 1 cycle.
//    Total req accept -> rsp_valid = W/2+4 = 20 cycles. Verification checks this count exactly.
//  Boundary cases:
//  - Zero with negative sign -> product 0, neg=0, zero=1.
//  - min*min signed -> +2^(2W-2), ovf=1, neg=0.
//  - req_valid while busy -> ignored (req_ready=0); the requester must hold req_valid.
//  - rsp_ready high in the same cycle rsp_valid rises -> 1-cycle RESP.
// STRUCTURE
//  Package mul_pkg:
//    - WIDTH default.
//    - state encoding (IDLE, ISSUE, WAIT, FIX, RESP).
//    - flag bit indices FLAG_OVF=0, FLAG_NEG=1, FLAG_ZERO=2.
//  One sub-module: mul_sign_fix (parameterised N, combinational two's-negate-if-sel). Instantiated twice at
//    N=WIDTH for the operands and once at N=2*WIDTH for the product.
//  Top: FSM, operand/result registers, flag logic.
// TESTING
//  Bench instantiates the sequencer with the real Multiplier, WIDTH=32, and a reference model in the bench.
//  1. signed, a=-3 (FFFFFFFD), b=5 -> product FFFFFFFF_FFFFFFF1, flags {0,1,0}; rsp_valid exactly 20 cycles after accept.
//  2. signed, a=b=80000000 -> product 40000000_00000000, flags {1,0,0}.
//  3. unsigned, a=b=FFFFFFFF -> product FFFFFFFE_00000001, flags {1,0,0}.
//     Same operands signed (-1*-1) -> 00000000_00000001, flags {0,0,0}.
//  4. signed, a=-7, b=0 -> product 0, flags {0,0,1}.
//     Signed a=113, b=31415 -> 3549895, flags {0,0,0}.
//  5. rsp_ready low for 5 cycles after rsp_valid -> product/flags stable, req_ready=0, new req_valid ignored.
//     Then a handshake completes and the next request is accepted 1 cycle later.
//  6. reset pulse while in WAIT -> all outputs at reset values next cycle, no rsp_valid.
//     The following request (35*63 unsigned) returns 2205 correctly.
//  Plus 1000 random signed/unsigned pairs against the bench reference model.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types for the signed multiply sequencer.
// State encoding, default width and flag positions.
package mul_pkg;

  localparam int WIDTH = 32;

  localparam int FLAG_OVF  = 0;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_ZERO = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_FIX,
    S_RESP
  } state_t;

endpackage

// File: rtl/signed_mul_sequencer_if.sv
// Request, multiplier and response signals of the sequencer.
// slave = sequencer side, master = requester/multiplier side.
interface signed_mul_sequencer_if #(
  parameter int W = mul_pkg::WIDTH
) ();

  logic           req_valid;
  logic           req_ready;
  logic           req_signed;
  logic [W-1:0]   req_a;
  logic [W-1:0]   req_b;

  logic           mul_start;
  logic [W-1:0]   mul_multiplier;
  logic [W-1:0]   mul_multiplicand;
  logic [2*W-1:0] mul_result;
  logic           mul_done;

  logic           rsp_valid;
  logic           rsp_ready;
  logic [2*W-1:0] rsp_product;
  logic [0:2]     rsp_flags;

  modport slave (
    input  req_valid, req_signed, req_a, req_b,
    output req_ready,
    output mul_start, mul_multiplier, mul_multiplicand,
    input  mul_result, mul_done,
    output rsp_valid, rsp_product, rsp_flags,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_signed, req_a, req_b,
    input  req_ready,
    input  mul_start, mul_multiplier, mul_multiplicand,
    output mul_result, mul_done,
    input  rsp_valid, rsp_product, rsp_flags,
    output rsp_ready
  );

endinterface

// File: rtl/mul_sign_fix.sv
// Conditional two's-complement negate.
// The most negative value maps onto itself.
module mul_sign_fix #(
  parameter int N = 32
) (
  input  logic [N-1:0] value,
  input  logic         sel,
  output logic [N-1:0] result
);

  localparam logic [N-1:0] ONE = 1;

  assign result = sel ? (~value + ONE) : value;

endmodule

// File: rtl/signed_mul_sequencer.sv
// Signed/unsigned front and back end around the
// unsigned start/done Multiplier.
module signed_mul_sequencer #(
  parameter int WIDTH = mul_pkg::WIDTH
) (
  input logic clock,
  input logic reset,
  signed_mul_sequencer_if.slave bus
);

  import mul_pkg::*;

  localparam int P = 2 * WIDTH;

  state_t state;
  state_t state_nx;

  logic req_rdy;
  logic start;
  logic rsp_vld;
  logic take_req;
  logic take_res;
  logic load_rsp;

  logic sel_a;
  logic sel_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

  logic sign;
  logic is_signed;
  logic [P-1:0] result;
  logic [P-1:0] product;
  logic [P-1:0] rsp_prod;
  logic [0:2] flags;
  logic [0:2] rsp_flg;
  logic [WIDTH:0] top;

  assign sel_a = bus.req_signed & bus.req_a[WIDTH-1];
  assign sel_b = bus.req_signed & bus.req_b[WIDTH-1];

  mul_sign_fix #(.N(WIDTH)) u_fix_a (
    .value  (bus.req_a),
    .sel    (sel_a),
    .result (mag_a)
  );

  mul_sign_fix #(.N(WIDTH)) u_fix_b (
    .value  (bus.req_b),
    .sel    (sel_b),
    .result (mag_b)
  );

  mul_sign_fix #(.N(P)) u_fix_p (
    .value  (result),
    .sel    (sign),
    .result (product)
  );

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // next state and handshake strobes
  always_comb begin
    state_nx = state;
    req_rdy  = 1'b0;
    start    = 1'b0;
    rsp_vld  = 1'b0;
    take_req = 1'b0;
    take_res = 1'b0;
    load_rsp = 1'b0;
    unique case (state)
      S_IDLE: begin
        req_rdy = !reset;
        if (bus.req_valid && !reset) begin
          take_req = 1'b1;
          state_nx = S_ISSUE;
        end
      end
      S_ISSUE: begin
        start = 1'b1;
        if (!bus.mul_done) state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (bus.mul_done) begin
          take_res = 1'b1;
          state_nx = S_FIX;
        end
      end
      S_FIX: begin
        load_rsp = 1'b1;
        state_nx = S_RESP;
      end
      S_RESP: begin
        rsp_vld = 1'b1;
        if (bus.rsp_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // operand magnitudes and result sign
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_a      <= '0;
      op_b      <= '0;
      sign      <= 1'b0;
      is_signed <= 1'b0;
    end else if (take_req) begin
      op_a      <= mag_a;
      op_b      <= mag_b;
      sign      <= bus.req_signed &
                   (bus.req_a[WIDTH-1] ^ bus.req_b[WIDTH-1]);
      is_signed <= bus.req_signed;
    end
  end

  // raw unsigned product, only once done returns high in WAIT
  always_ff @(posedge clock or posedge reset) begin
    if (reset)         result <= '0;
    else if (take_res) result <= bus.mul_result;
  end

  // condition flags on the sign-corrected product
  always_comb begin
    flags = '0;
    top   = product[P-1:WIDTH-1];
    flags[FLAG_ZERO] = (product == '0);
    flags[FLAG_NEG]  = is_signed & product[P-1];
    if (is_signed) flags[FLAG_OVF] = !((&top) | (~|top));
    else           flags[FLAG_OVF] = |product[P-1:WIDTH];
  end

  // response registers, held through RESP
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_prod <= '0;
      rsp_flg  <= '0;
    end else if (load_rsp) begin
      rsp_prod <= product;
      rsp_flg  <= flags;
    end
  end

  assign bus.req_ready        = req_rdy;
  assign bus.mul_start        = start;
  assign bus.mul_multiplier   = op_a;
  assign bus.mul_multiplicand = op_b;
  assign bus.rsp_valid        = rsp_vld;
  assign bus.rsp_product      = rsp_prod;
  assign bus.rsp_flags        = rsp_flg;

endmodule

// File: tb/tb_signed_mul_sequencer.sv
// Bench for signed_mul_sequencer with a start/done multiplier
// model, scoreboard queue and arithmetic reference model.
module tb_signed_mul_sequencer;

  localparam int W = 32;
  localparam int LAT = W / 2 + 4;

  typedef struct {
    logic [63:0] p;
    logic [0:2]  f;
    int          acc;
  } exp_t;

  typedef struct {
    bit          s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
    logic [0:2]  f;
  } vec_t;

  logic clock;
  logic reset;

  signed_mul_sequencer_if #(.W(W)) bus ();

  signed_mul_sequencer #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t sb[$];
  bit   rand_rdy = 0;
  bit   holding = 0;
  exp_t cur;

  initial clock = 0;
  always #5 clock = ~clock;

  // cycle count, advanced on every active edge
  always @(posedge clock) cyc <= cyc + 1;

  // multiplier model: busy W/2+1 cycles, garbage on result while busy
  int unsigned mcnt;
  logic [63:0] mprod;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.mul_done   <= 1'b1;
      bus.mul_result <= '0;
      mcnt           <= 0;
    end else if (bus.mul_done) begin
      if (bus.mul_start) begin
        bus.mul_done <= 1'b0;
        mcnt         <= W / 2 + 1;
        mprod        <= {32'b0, bus.mul_multiplier} *
                        {32'b0, bus.mul_multiplicand};
      end
    end else begin
      bus.mul_result <= {$urandom, $urandom};
      if (mcnt == 1) begin
        bus.mul_done   <= 1'b1;
        bus.mul_result <= mprod;
      end
      mcnt <= mcnt - 1;
    end
  end

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h at cycle %0d",
               name, act, req, cyc);
    end
  endtask

  function automatic exp_t model(bit s, logic [31:0] a,
                                 logic [31:0] b);
    exp_t   e;
    longint sp;
    if (s) begin
      sp = longint'($signed(a)) * longint'($signed(b));
      e.p = sp;
      e.f[0] = (sp > 64'sd2147483647) || (sp < -64'sd2147483648);
      e.f[1] = (sp < 0);
    end else begin
      e.p = {32'b0, a} * {32'b0, b};
      e.f[0] = (e.p[63:32] != 0);
      e.f[1] = 1'b0;
    end
    e.f[2] = (e.p == 0);
    e.acc = 0;
    return e;
  endfunction

  // randomised consumer back-pressure
  always @(negedge clock)
    if (rand_rdy) bus.rsp_ready = ($urandom_range(0, 3) != 0);

  // monitor: pop and compare on each new response, recheck while held
  always @(negedge clock) begin
    if (reset || !bus.rsp_valid) begin
      holding = 0;
    end else if (!holding) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got %h want none",
                 bus.rsp_product);
      end else begin
        cur = sb.pop_front();
        holding = 1;
        chk("product", bus.rsp_product, cur.p);
        chk("flags", 64'(bus.rsp_flags), 64'(cur.f));
        chk("latency", 64'(cyc - cur.acc), 64'(LAT));
      end
    end else begin
      chk("hold_product", bus.rsp_product, cur.p);
      chk("hold_flags", 64'(bus.rsp_flags), 64'(cur.f));
      chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
    end
  end

  // present a request, push its expectation at the accepting edge
  task automatic do_req(bit s, logic [31:0] a, logic [31:0] b,
                        exp_t e, output int acc);
    bus.req_valid  = 1'b1;
    bus.req_signed = s;
    bus.req_a      = a;
    bus.req_b      = b;
    acc = -1;
    for (int i = 0; i < 300; i++) begin
      if (bus.req_ready) begin
        acc = cyc + 1;
        break;
      end
      @(negedge clock);
    end
    if (acc < 0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got req_ready 0 want 1");
      bus.req_valid = 1'b0;
    end else begin
      e.acc = acc;
      sb.push_back(e);
      @(posedge clock);
      #1;
      bus.req_valid = 1'b0;
      @(negedge clock);
    end
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0 && !bus.rsp_valid) begin
        ok = 1;
        break;
      end
      @(negedge clock);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending want 0",
               sb.size());
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_mul_start", 64'(bus.mul_start), 64'd0);
    chk("rst_multiplier", 64'(bus.mul_multiplier), 64'd0);
    chk("rst_multiplicand", 64'(bus.mul_multiplicand), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_product", bus.rsp_product, 64'd0);
    chk("rst_rsp_flags", 64'(bus.rsp_flags), 64'd0);
  endtask

  vec_t dir[6];
  logic [31:0] spec_v[6];

  initial begin
    int   acc;
    int   acc2;
    int   h;
    bit   seen;
    exp_t e;
    logic [31:0] ra;
    logic [31:0] rb;
    bit   rs;

    dir[0] = '{1, 32'hFFFFFFFD, 32'd5,
               64'hFFFFFFFF_FFFFFFF1, 3'b010};
    dir[1] = '{1, 32'h80000000, 32'h80000000,
               64'h40000000_00000000, 3'b100};
    dir[2] = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF,
               64'hFFFFFFFE_00000001, 3'b100};
    dir[3] = '{1, 32'hFFFFFFFF, 32'hFFFFFFFF,
               64'h00000000_00000001, 3'b000};
    dir[4] = '{1, 32'hFFFFFFF9, 32'd0,
               64'h0, 3'b001};
    dir[5] = '{1, 32'd113, 32'd31415,
               64'd3549895, 3'b000};

    spec_v = '{32'h0, 32'h1, 32'hFFFFFFFF,
               32'h80000000, 32'h7FFFFFFF, 32'h80000001};

    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_signed = 1'b0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.rsp_ready  = 1'b1;
    repeat (2) @(negedge clock);
    chk_reset_vals();
    reset = 1'b0;
    @(negedge clock);
    chk("idle_req_ready", 64'(bus.req_ready), 64'd1);

    foreach (dir[i]) begin
      e.p = dir[i].p;
      e.f = dir[i].f;
      do_req(dir[i].s, dir[i].a, dir[i].b, e, acc);
    end
    drain();

    // stalled response, request presented while busy
    bus.rsp_ready = 1'b0;
    do_req(0, 32'd1234, 32'd5678, model(0, 32'd1234, 32'd5678), acc);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.rsp_valid) begin
        seen = 1;
        break;
      end
      @(negedge clock);
    end
    chk("stall_rsp_seen", 64'(seen), 64'd1);
    bus.req_valid  = 1'b1;
    bus.req_signed = 1'b1;
    bus.req_a      = 32'hFFFFFFF9;
    bus.req_b      = 32'd9;
    repeat (5) begin
      @(negedge clock);
      chk("busy_req_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    h = cyc + 1;
    do_req(1, 32'hFFFFFFF9, 32'd9,
           model(1, 32'hFFFFFFF9, 32'd9), acc2);
    chk("accept_after_rsp", 64'(acc2), 64'(h + 1));
    drain();

    // reset pulse while the multiplier is busy
    do_req(0, 32'd1000, 32'd1000, model(0, 32'd1000, 32'd1000), acc);
    repeat (6) @(negedge clock);
    chk("in_wait_busy", 64'(bus.mul_done), 64'd0);
    reset = 1'b1;
    sb.delete();
    @(posedge clock);
    #1;
    chk_reset_vals();
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clock);
      if (bus.rsp_valid) seen = 1;
    end
    chk("no_rsp_after_reset", 64'(seen), 64'd0);
    e.p = 64'd2205;
    e.f = 3'b000;
    do_req(0, 32'd35, 32'd63, e, acc);
    drain();

    // random traffic with random back-pressure
    rand_rdy = 1;
    for (int n = 0; n < 1000; n++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) ra = spec_v[$urandom_range(0, 5)];
      if ($urandom_range(0, 7) == 0) rb = spec_v[$urandom_range(0, 5)];
      if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(1, 31);
      do_req(rs, ra, rb, model(rs, ra, rb), acc);
    end
    drain();
    rand_rdy = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
